// File: rtl/div_pkg.sv
// Shared definitions for the parametrised restoring divider.
// Imported by div_param and div_clz.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'd0,
        DIV_BYZERO = 2'd1,
        DIV_ON     = 2'd2,
        DIV_END    = 2'd3
    } div_state_e;

    localparam logic DIV_START     = 1'b1;
    localparam logic DIV_STOP      = 1'b0;
    localparam logic DIV_READY     = 1'b1;
    localparam logic DIV_NOT_READY = 1'b0;

    // Widest operand the zero test accepts; callers zero-extend into it.
    localparam int DIV_MAX_W = 4096;

    function automatic logic div_is_zero(input logic [DIV_MAX_W-1:0] w);
        return w == '0;
    endfunction

endpackage

// File: rtl/div_clz.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
// Used by div_param only when DIV_EARLY_EXIT_EN is defined.
module div_clz
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value_i,
    output logic [CW-1:0]    count_o
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        count_o = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value_i[i]) begin
                count_o = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/div_param.sv
// Multicycle radix-2 restoring divider, signed/unsigned, start/ready/cancel.
// Define DIV_EARLY_EXIT_EN to skip leading-zero iterations of the dividend.
module div_param
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               cancel_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               div_zero_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 2 * WIDTH + 1;

    div_state_e state_q, state_d;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [SW-1:0]      sh_q, sh_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               sgn_q, sgn_d;
    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    logic               dz_q, dz_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;
    logic               div_zero_q, div_zero_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   a_pre;
    logic [CW-1:0]      lz;
    logic               accept;
    logic               b_zero;
    logic [WIDTH+1:0]   diff;
    logic               borrow;
    logic [WIDTH-1:0]   quo_raw, rem_raw;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign a_neg  = signed_div_i & opdata1_i[WIDTH-1];
    assign b_neg  = signed_div_i & opdata2_i[WIDTH-1];
    assign a_mag  = a_neg ? -opdata1_i : opdata1_i;
    assign b_mag  = b_neg ? -opdata2_i : opdata2_i;
    assign b_zero = div_is_zero(DIV_MAX_W'(opdata2_i));
    assign accept = (start_i == DIV_START) && !cancel_i;

`ifdef DIV_EARLY_EXIT_EN
    div_clz #(
        .WIDTH (WIDTH)
    ) u_clz (
        .value_i (a_mag),
        .count_o (lz)
    );
`else
    assign lz = '0;
`endif

    // Leading zeros of the dividend contribute only zero quotient bits.
    assign a_pre = a_mag << lz;

    // Partial remainder plus next dividend bit sits in sh_q[2W:W].
    assign diff   = {1'b0, sh_q[SW-1:WIDTH]} - {2'b0, dvs_q};
    assign borrow = diff[WIDTH+1];

    // Fix-up stores rem at [2W:W+1] and quo at [W-1:0], same as in ON.
    assign quo_raw = sh_q[WIDTH-1:0];
    assign rem_raw = sh_q[SW-1:WIDTH+1];
    assign quo_fix = (sgn_q & (s1_q ^ s2_q)) ? -quo_raw : quo_raw;
    assign rem_fix = (sgn_q & s1_q) ? -rem_raw : rem_raw;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        dvs_d      = dvs_q;
        sgn_d      = sgn_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        dz_d       = dz_q;
        result_d   = result_q;
        ready_d    = ready_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            DIV_FREE: begin
                result_d   = '0;
                ready_d    = DIV_NOT_READY;
                div_zero_d = 1'b0;
                if (accept) begin
                    sgn_d = signed_div_i;
                    s1_d  = opdata1_i[WIDTH-1];
                    s2_d  = opdata2_i[WIDTH-1];
                    dvs_d = b_mag;
                    dz_d  = 1'b0;
                    cnt_d = lz;
                    sh_d  = {WIDTH'(0), a_pre, 1'b0};
                    if (b_zero) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d = DIV_ON;
                    end
                end
            end

            DIV_BYZERO: begin
                if (cancel_i) begin
                    state_d = DIV_FREE;
                end else begin
                    sh_d    = '0;
                    dz_d    = 1'b1;
                    state_d = DIV_END;
                end
            end

            DIV_ON: begin
                if (cancel_i) begin
                    state_d = DIV_FREE;
                end else if (cnt_q != CW'(WIDTH)) begin
                    if (borrow) begin
                        sh_d = {sh_q[SW-2:0], 1'b0};
                    end else begin
                        sh_d = {diff[WIDTH-1:0], sh_q[WIDTH-1:0], 1'b1};
                    end
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    sh_d    = {rem_fix, 1'b0, quo_fix};
                    state_d = DIV_END;
                end
            end

            DIV_END: begin
                result_d   = {rem_raw, quo_raw};
                ready_d    = DIV_READY;
                div_zero_d = dz_q;
                if (start_i == DIV_STOP) begin
                    state_d    = DIV_FREE;
                    result_d   = '0;
                    ready_d    = DIV_NOT_READY;
                    div_zero_d = 1'b0;
                end
            end

            default: begin
                state_d = DIV_FREE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            sh_q       <= '0;
            dvs_q      <= '0;
            sgn_q      <= 1'b0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            dz_q       <= 1'b0;
            result_q   <= '0;
            ready_q    <= DIV_NOT_READY;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            dvs_q      <= dvs_d;
            sgn_q      <= sgn_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            dz_q       <= dz_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign div_zero_o = div_zero_q;
    assign busy_o     = (state_q != DIV_FREE);

endmodule

// File: tb/tb_div_param.sv
// Self-checking bench for div_param (WIDTH=32) against an arithmetic model.
// Honours DIV_EARLY_EXIT_EN for the expected latency.
module tb_div_param;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           signed_div = 1'b0;
    logic [W-1:0]   opdata1 = '0;
    logic [W-1:0]   opdata2 = '0;
    logic           start = 1'b0;
    logic           cancel = 1'b0;
    logic [2*W-1:0] result_o;
    logic           ready_o;
    logic           busy_o;
    logic           div_zero_o;

    int n_run  = 0;
    int n_fail = 0;

    div_param #(
        .WIDTH (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .cancel_i     (cancel),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o),
        .div_zero_o   (div_zero_o)
    );

    always #5 clk = ~clk;

    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sg, output logic [W-1:0] q,
                         output logic [W-1:0] r, output logic z,
                         output int lat);
        longint sa, sb, lq, lr;
        logic [W-1:0] mag;
        int lzc;
        sa = sg ? longint'($signed(a)) : longint'(a);
        sb = sg ? longint'($signed(b)) : longint'(b);
        if (b == '0) begin
            q = '0;
            r = '0;
            z = 1'b1;
            lat = 2;
        end else begin
            lq = sa / sb;
            lr = sa % sb;
            q = lq[W-1:0];
            r = lr[W-1:0];
            z = 1'b0;
            lat = W + 2;
`ifdef DIV_EARLY_EXIT_EN
            mag = (sa < 0) ? W'(-sa) : a;
            lzc = W - $clog2(longint'(mag) + 1);
            lat = W - lzc + 2;
`else
            mag = a;
            lzc = 0;
`endif
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sg, input string tag);
        logic [W-1:0] eq, er;
        logic ez;
        int elat, lat;
        bit seen;
        model(a, b, sg, eq, er, ez, elat);
        @(negedge clk);
        opdata1 = a;
        opdata2 = b;
        signed_div = sg;
        start = 1'b1;
        cancel = 1'b0;
        lat = -1;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #1;
            opdata1 = $urandom;
            opdata2 = $urandom;
            signed_div = 1'($urandom);
            @(negedge clk);
            if (i == 0) begin
                n_run++;
                if (busy_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy: got %b want 1", tag, busy_o);
                end
            end
            if (ready_o === 1'b1) begin
                seen = 1;
                lat = i;
            end
        end
        n_run++;
        if (lat != elat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", tag, lat, elat);
        end
        n_run++;
        if (result_o !== {er, eq}) begin
            n_fail++;
            $display("FAIL %s result: got %h want %h", tag, result_o, {er, eq});
        end
        n_run++;
        if (div_zero_o !== ez) begin
            n_fail++;
            $display("FAIL %s div_zero: got %b want %b", tag, div_zero_o, ez);
        end
        cancel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_run++;
        if (ready_o !== 1'b1 || result_o !== {er, eq}) begin
            n_fail++;
            $display("FAIL %s hold: got ready=%b res=%h want 1 %h",
                     tag, ready_o, result_o, {er, eq});
        end
        cancel = 1'b0;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_run++;
        if ({ready_o, busy_o, div_zero_o, result_o} !== '0) begin
            n_fail++;
            $display("FAIL %s release: got r=%b b=%b z=%b res=%h want all 0",
                     tag, ready_o, busy_o, div_zero_o, result_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_run++;
        if ({ready_o, busy_o, div_zero_o, result_o} !== '0) begin
            n_fail++;
            $display("FAIL reset: got r=%b b=%b z=%b res=%h want all 0",
                     ready_o, busy_o, div_zero_o, result_o);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_op(32'd100, 32'd7, 1'b0, "u100_7");
        do_op(-32'sd7, 32'd2, 1'b1, "sm7_2");
        do_op(32'd7, -32'sd2, 1'b1, "s7_m2");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "min_m1");
        do_op(32'd5, 32'd0, 1'b0, "div0");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "u_big");
        do_op(32'd3, 32'd10, 1'b0, "small");
    endtask

    task automatic test_early_exit();
        do_op(32'd1, 32'd1, 1'b0, "one_one");
        do_op(32'd0, 32'd5, 1'b0, "zero_num");
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, "full_num");
    endtask

    task automatic test_cancel();
        bit saw_ready;
        @(negedge clk);
        opdata1 = 32'hFFFF_FFFF;
        opdata2 = 32'd3;
        signed_div = 1'b0;
        start = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cancel = 1'b0;
        n_run++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_busy: got %b want 0", busy_o);
        end
        saw_ready = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o !== 1'b0) saw_ready = 1;
        end
        n_run++;
        if (saw_ready) begin
            n_fail++;
            $display("FAIL cancel_ready: got 1 want 0");
        end
        @(negedge clk);
        opdata2 = 32'd0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cancel = 1'b0;
        n_run++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_byzero: got b=%b r=%b want 0 0",
                     busy_o, ready_o);
        end
        do_op(32'd9, 32'd3, 1'b0, "after_cancel");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        opdata1 = 32'd100;
        opdata2 = 32'd7;
        signed_div = 1'b0;
        start = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_run++;
        if ({ready_o, busy_o, div_zero_o, result_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got r=%b b=%b z=%b res=%h want all 0",
                     ready_o, busy_o, div_zero_o, result_o);
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_op(32'd100, 32'd7, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        int sel;
        for (int k = 0; k < 60; k++) begin
            a = $urandom >> $urandom_range(0, 31);
            sel = $urandom_range(0, 9);
            if (sel == 0) b = '0;
            else if (sel < 5) b = W'($urandom_range(1, 15));
            else b = $urandom >> $urandom_range(0, 31);
            if (sel == 9) b = -b;
            do_op(a, b, 1'($urandom), $sformatf("rnd%0d", k));
        end
    endtask

    task automatic test_back_to_back();
        do_op(32'd1000, 32'd33, 1'b0, "b2b_a");
        do_op(-32'sd1000, 32'd33, 1'b1, "b2b_b");
        do_op(32'd77, 32'd0, 1'b1, "b2b_c");
        do_op(32'd77, -32'sd5, 1'b1, "b2b_d");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_early_exit();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
